// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package cache_pkg;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_INDEX_BITS = 4;
    localparam int unsigned DEF_WORD_BITS  = 2;
    localparam int unsigned BYTE_BITS      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_FILL   = 2'd2
    } state_e;

    // Bit position where the line index starts within a byte address.
    function automatic int unsigned index_lsb(input int unsigned word_bits);
        return BYTE_BITS + word_bits;
    endfunction

    // Tag width left over after byte, word and index fields.
    function automatic int unsigned tag_bits(input int unsigned width,
                                             input int unsigned index_bits,
                                             input int unsigned word_bits);
        return width - index_lsb(word_bits) - index_bits;
    endfunction

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side handshake signals of the instruction cache.
interface icache_direct_if #(
    parameter int unsigned WIDTH = cache_pkg::DEF_WIDTH
) ();

    logic             cpu_req;
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_rdata;
    logic             cpu_ready;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_valid;

    modport slave (
        input  cpu_req, cpu_addr, mem_rdata, mem_valid,
        output cpu_rdata, cpu_ready, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, mem_rdata, mem_valid,
        input  cpu_rdata, cpu_ready, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_store.sv
// Data, tag and valid arrays of the cache with a combinational hit compare.
module icache_store #(
    parameter int unsigned WIDTH      = cache_pkg::DEF_WIDTH,
    parameter int unsigned INDEX_BITS = cache_pkg::DEF_INDEX_BITS,
    parameter int unsigned WORD_BITS  = cache_pkg::DEF_WORD_BITS,
    parameter int unsigned TAG_BITS   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_BITS-1:0]   rd_tag,
    input  logic [WORD_BITS-1:0]  rd_offset,
    output logic                  hit_c,
    output logic [WIDTH-1:0]      rdata_c,
    input  logic                  dwr_en,
    input  logic [INDEX_BITS-1:0] dwr_index,
    input  logic [WORD_BITS-1:0]  dwr_offset,
    input  logic [WIDTH-1:0]      dwr_data,
    input  logic                  twr_en,
    input  logic [INDEX_BITS-1:0] twr_index,
    input  logic [TAG_BITS-1:0]   twr_tag,
    input  logic                  vclr
);

    localparam int unsigned LINES = 2 ** INDEX_BITS;
    localparam int unsigned WORDS = 2 ** WORD_BITS;

    logic [WIDTH-1:0]    data_q  [LINES][WORDS];
    logic [WIDTH-1:0]    data_d  [LINES][WORDS];
    logic [TAG_BITS-1:0] tag_q   [LINES];
    logic [TAG_BITS-1:0] tag_d   [LINES];
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    valid_d;

    // A clear outranks a same-cycle tag write so a flushed line never validates.
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        if (dwr_en) begin
            data_d[dwr_index][dwr_offset] = dwr_data;
        end
        if (twr_en) begin
            tag_d[twr_index]   = twr_tag;
            valid_d[twr_index] = 1'b1;
        end
        if (vclr) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign hit_c   = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rdata_c = data_q[rd_index][rd_offset];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stalling line refill on miss.
module icache_direct
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
    parameter int unsigned WORD_BITS  = DEF_WORD_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    icache_direct_if.slave   bus,
    output logic [WIDTH-1:0] hit_count,
    output logic [WIDTH-1:0] miss_count
);

    localparam int unsigned INDEX_LSB = index_lsb(WORD_BITS);
    localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_BITS;
    localparam int unsigned TAG_BITS  = tag_bits(WIDTH, INDEX_BITS, WORD_BITS);
    localparam int unsigned WORDS     = 2 ** WORD_BITS;
    localparam logic [WIDTH-1:0]     LINE_MASK = ~WIDTH'((2 ** INDEX_LSB) - 1);
    localparam logic [WORD_BITS-1:0] LAST_K    = WORD_BITS'(WORDS - 1);

    state_e                state_q, state_d;
    logic [WORD_BITS-1:0]  k_q, k_d;
    logic [INDEX_BITS-1:0] line_idx_q, line_idx_d;
    logic [TAG_BITS-1:0]   line_tag_q, line_tag_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  mem_req_q, mem_req_d;
    logic [WIDTH-1:0]      mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      hit_count_q, hit_count_d;
    logic [WIDTH-1:0]      miss_count_q, miss_count_d;

    logic [INDEX_BITS-1:0] cpu_index;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic [WORD_BITS-1:0]  cpu_offset;
    logic                  store_hit_c;
    logic [WIDTH-1:0]      store_rdata_c;
    logic                  lookup_hit_c;
    logic                  cpu_ready_c;
    logic [WIDTH-1:0]      cpu_rdata_c;
    logic                  dwr_en_c, twr_en_c, vclr_c;
    logic                  unused_addr;

    assign cpu_offset  = bus.cpu_addr[BYTE_BITS +: WORD_BITS];
    assign cpu_index   = bus.cpu_addr[INDEX_LSB +: INDEX_BITS];
    assign cpu_tag     = bus.cpu_addr[TAG_LSB +: TAG_BITS];
    assign unused_addr = ^bus.cpu_addr[BYTE_BITS-1:0];

    icache_store #(
        .WIDTH      (WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (cpu_index),
        .rd_tag     (cpu_tag),
        .rd_offset  (cpu_offset),
        .hit_c      (store_hit_c),
        .rdata_c    (store_rdata_c),
        .dwr_en     (dwr_en_c),
        .dwr_index  (line_idx_q),
        .dwr_offset (k_q),
        .dwr_data   (bus.mem_rdata),
        .twr_en     (twr_en_c),
        .twr_index  (line_idx_q),
        .twr_tag    (line_tag_q),
        .vclr       (vclr_c)
    );

    // Lookup, refill sequencing and counters.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        line_idx_d   = line_idx_q;
        line_tag_d   = line_tag_q;
        flush_pend_d = flush_pend_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        lookup_hit_c = 1'b0;
        cpu_ready_c  = 1'b0;
        cpu_rdata_c  = '0;
        dwr_en_c     = 1'b0;
        twr_en_c     = 1'b0;
        vclr_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lookup_hit_c = bus.cpu_req && store_hit_c && !flush;
                cpu_ready_c  = !flush && (!bus.cpu_req || lookup_hit_c);
                cpu_rdata_c  = lookup_hit_c ? store_rdata_c : '0;
                if (flush) begin
                    vclr_c = 1'b1;
                end else if (lookup_hit_c) begin
                    hit_count_d = hit_count_q + WIDTH'(1);
                end else if (bus.cpu_req) begin
                    line_idx_d   = cpu_index;
                    line_tag_d   = cpu_tag;
                    k_d          = '0;
                    flush_pend_d = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = bus.cpu_addr & LINE_MASK;
                    miss_count_d = miss_count_q + WIDTH'(1);
                    state_d      = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.mem_valid) begin
                    dwr_en_c = 1'b1;
                    if (k_q == LAST_K) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_FILL;
                    end else begin
                        k_d        = k_q + WORD_BITS'(1);
                        mem_addr_d = mem_addr_q + WIDTH'(4);
                    end
                end
            end
            ST_FILL: begin
                if (flush_pend_q || flush) begin
                    vclr_c = 1'b1;
                end else begin
                    twr_en_c = 1'b1;
                end
                flush_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            line_idx_q   <= '0;
            line_tag_q   <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            line_idx_q   <= line_idx_d;
            line_tag_q   <= line_tag_d;
            flush_pend_q <= flush_pend_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.cpu_ready = cpu_ready_c;
    assign bus.cpu_rdata = cpu_rdata_c;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: fetch data and memory addresses checked by a monitor.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        stray = 1'b0;
    int          wait_cfg = 0;
    logic [3:0]  wait_cnt = '0;
    logic [31:0] hit_count, miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] addr_q [$];

    logic        prev_req = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr = '0;

    icache_direct_if #(.WIDTH(32)) bus ();

    icache_direct #(.WIDTH(32), .INDEX_BITS(4), .WORD_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Memory contents: word i of line L holds 0xA000_0000 + L + i.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'hA000_0000 + (a & 32'hFFFF_FFF0) + ((a >> 2) & 32'h3);
    endfunction

    assign bus.mem_rdata = memword(bus.mem_addr);
    assign bus.mem_valid = stray || (bus.mem_req && (32'(wait_cnt) == wait_cfg));

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_valid) wait_cnt <= '0;
        else                               wait_cnt <= wait_cnt + 4'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT delivers data or accepts a memory word.
    always @(negedge clk) begin
        if (bus.cpu_req && bus.cpu_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_delivery: got %h expected none", bus.cpu_rdata);
            end else begin
                chk("cpu_rdata", bus.cpu_rdata, exp_q.pop_front());
            end
        end
        if (bus.mem_req && bus.mem_valid) begin
            if (addr_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_mem_word: got %h expected none", bus.mem_addr);
            end else begin
                chk("mem_addr", bus.mem_addr, addr_q.pop_front());
            end
        end
        if (bus.mem_req && prev_req && !prev_valid)
            chk("mem_addr_hold", bus.mem_addr, prev_addr);
        prev_req   <= bus.mem_req;
        prev_valid <= bus.mem_valid;
        prev_addr  <= bus.mem_addr;
    end

    task automatic fetch(input logic [31:0] a, input int exp_cyc, input int nrefill);
        int  cyc;
        bit  done;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        exp_q.push_back(memword(a));
        for (int r = 0; r < nrefill; r++)
            for (int i = 0; i < 4; i++)
                addr_q.push_back((a & 32'hFFFF_FFF0) + 32'(4 * i));
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (cyc >= 200) begin
                    n_checks++; n_fail++;
                    $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles", a, cyc);
                    exp_q.delete();
                    addr_q.delete();
                    done = 1'b1;
                end
            end
        end
        chk("latency", 32'(cyc), 32'(exp_cyc));
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input int exp_hits, input int exp_misses);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("hit_count", hit_count, 32'(exp_hits));
        chk("miss_count", miss_count, 32'(exp_misses));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        @(posedge clk); #1;

        // Cold miss, zero-wait memory
        fetch(32'h0000_0044, 6, 1);
        idle_check(1, 1);

        // Hits across the filled line
        for (int i = 0; i < 4; i++) begin
            fetch(32'h0000_0040 + 32'(4 * i), 0, 0);
            chk("hit_no_mem_req", 32'(bus.mem_req), 32'd0);
        end
        idle_check(5, 1);

        // Flush while idle blocks the cycle
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", 32'(bus.cpu_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;

        // Conflict eviction on index 4
        fetch(32'h0000_0040, 6, 1);
        fetch(32'h0000_0140, 6, 1);
        fetch(32'h0000_0040, 6, 1);
        idle_check(8, 4);

        // Three wait states per word
        wait_cfg = 3;
        fetch(32'h0000_0080, 18, 1);
        wait_cfg = 0;
        idle_check(9, 5);

        // Flush during refill invalidates everything, line refetched twice
        fetch(32'h0000_0140, 6, 1);
        fetch(32'h0000_0100, 6, 1);
        fork
            fetch(32'h0000_0040, 12, 2);
            begin
                repeat (2) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        idle_check(12, 9);
        fetch(32'h0000_0100, 6, 1);
        idle_check(13, 10);

        // Reset with k == 2 abandons the refill
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0200;
        addr_q.push_back(32'h0000_0200);
        addr_q.push_back(32'h0000_0204);
        addr_q.push_back(32'h0000_0208);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        chk("rst2_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst2_mem_addr", bus.mem_addr, 32'd0);
        chk("rst2_hit_count", hit_count, 32'd0);
        chk("rst2_miss_count", miss_count, 32'd0);
        chk("rst2_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        chk("rst2_cpu_rdata", bus.cpu_rdata, 32'd0);
        @(posedge clk); #1;
        stray = 1'b0;
        fetch(32'h0000_0040, 6, 1);
        idle_check(1, 1);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("addr_q_drained", 32'(addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipeline's PC/fetch stage and a slower word-wide instruction memory.
- Hits return the instruction combinationally in the same cycle, as the fetch stage expects from the ROM today.
- Misses hold cpu_ready low; the fetch stage stalls, retaining PC and IF/ID, while a multi-cycle line refill runs over a req/valid memory handshake.

Parameters:
- WIDTH, 32, data/address width.
- INDEX_BITS, 4, line index width (16 lines).
- WORD_BITS, 2, word-in-line select width (4 words per line).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  WIDTH  fetch byte address; bits [1:0] are ignored.
- cpu_rdata  out  WIDTH  instruction; valid when cpu_ready & cpu_req.
- cpu_ready  out  1  hit this cycle; 0 means stall.
- flush  in  1  invalidate all lines.
- mem_req  out  1  word read request to memory.
- mem_addr  out  WIDTH  word-aligned memory read address.
- mem_rdata  in  WIDTH  memory read data.
- mem_valid  in  1  mem_rdata valid; at most one per mem_req word.
- hit_count  out  WIDTH  number of hit cycles.
- miss_count  out  WIDTH  number of misses.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst; the polarity and synchronicity are fixed.
- Address split: offset = cpu_addr[WORD_BITS+1:2], index = next INDEX_BITS bits, tag = remaining upper bits.
- Storage: data array of 2^INDEX_BITS x 2^WORD_BITS words; tag array; valid bit per line.
- Reset (sync, rst=1 at posedge):
  - all valid bits = 0, state = IDLE, refill counter = 0;
  - mem_req = 0, mem_addr = 0;
  - hit_count = 0, miss_count = 0.
  - Outputs after reset: cpu_ready = !cpu_req, cpu_rdata = 0.
  - Reset mid-refill abandons the refill; a late mem_valid in IDLE is ignored.
- hit = cpu_req & valid[index] & (tag_array[index] == tag), evaluated in IDLE only.
- cpu_ready = (state == IDLE) & (!cpu_req | hit). cpu_rdata = data[index][offset] on hit, else 0.
- State IDLE:
  - On a hit, hit_count++.
  - On cpu_req & !hit, latch the line base (tag, index, offset = 0), set k = 0, miss_count++, and go to REFILL.
- State REFILL:
  - mem_req = 1 and mem_addr = line_base + 4*k, both registered.
  - On mem_valid, write mem_rdata to data[latched_index][k] and increment k.
  - When mem_valid arrives with k == 2^WORD_BITS - 1, go to FILL.
  - mem_req deasserts in the same edge that moves to FILL.
  - While mem_valid is low, state and address hold; memory wait states are unbounded.
- State FILL (1 cycle):
  - Write tag_array[latched_index] and set valid = 1, unless a flush is pending.
  - Return to IDLE. cpu_ready = 0 in this state.
- Miss latency: refill cycles plus 1 (FILL) plus the re-lookup. With zero-wait memory (mem_valid the cycle after mem_req), the instruction is delivered 6 cycles after the miss cycle.
- cpu_addr may change during refill (pipeline redirect). The refill always completes for the latched line, and the IDLE lookup then uses the current cpu_addr.
- flush in IDLE: all valid bits clear at that edge. cpu_ready is 0 in the flush cycle; the following cycle misses.
- flush in REFILL or FILL:
  - Sets flush_pending, and the refill continues.
  - At FILL, all valid bits clear and the new line is not validated; flush_pending clears.
- The counters wrap modulo 2^WIDTH. Stall cycles with cpu_req low count as neither hit nor miss.

Decomposition:
- Shared package cache_pkg holds the state encoding (IDLE, REFILL, FILL) and the address-field width constants derived from WIDTH, INDEX_BITS and WORD_BITS.
- One natural sub-module: icache_store, which contains the data, tag and valid arrays plus the hit compare. It has a single write port for data and a separate tag/valid write, and the valid clear is synchronous.

Test Plan:
- Cold miss: rst, then cpu_req=1 with cpu_addr=0x0000_0044 and memory returning word i = 0xA000_0040+i with zero wait states.
  - mem_addr must sequence 0x40, 0x44, 0x48, 0x4C.
  - cpu_ready must rise 6 cycles after the request, with cpu_rdata = 0xA000_0041.
  - miss_count must read 1.
- Hit after fill: cpu_addr 0x40 → 0x4C, one per cycle.
  - cpu_ready = 1 every cycle, cpu_rdata = 0xA000_0040..43, hit_count += 4, no mem_req.
- Conflict eviction: fetch 0x40, then 0x140 (same index, different tag), then 0x40.
  - Three refills; miss_count = 3; the data after each refill matches the new line.
- Memory wait states: mem_valid delayed 3 cycles per word on a miss to 0x80.
  - mem_addr holds steady during each wait.
  - Refill takes 16 cycles, then FILL, then a hit with the correct word.
- Flush mid-refill: assert flush during the REFILL of line 0x40 after 0x100 is already cached.
  - After FILL, both 0x40 and 0x100 miss (valid cleared); miss_count increments for each.
- Reset mid-refill: assert rst with k=2.
  - Next cycle: state IDLE, mem_req=0, counters=0.
  - A stray mem_valid is ignored, and a fetch of 0x40 misses.
